// File: rtl/dsp_overpack_unpack_acc_if.sv
// Handshake bundle between the overpacked DSP stage, the unpack/accumulate block
// and the activation/requant consumer.
interface dsp_overpack_unpack_acc_if #(
    parameter int NFIELD = 6,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 10,
    parameter int P_W    = 48
);
    logic [P_W-1:0]          P;
    logic                    p_valid;
    logic                    p_last;
    logic                    in_ready;
    logic [NFIELD*ACC_W-1:0] acc_out;
    logic [CNT_W-1:0]        beat_cnt;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output P, p_valid, p_last, out_ready,
        input  in_ready, acc_out, beat_cnt, out_valid
    );

    modport slave (
        input  P, p_valid, p_last, out_ready,
        output in_ready, acc_out, beat_cnt, out_valid
    );
endinterface

// File: rtl/dsp_overpack_unpack_acc.sv
// Unpacks six borrow-corrected signed products from the DSP P word, accumulates
// them per run with saturation, and hands the run totals downstream.
module dsp_overpack_unpack_acc #(
    parameter int FIELD_W = 6,
    parameter int NFIELD  = 6,
    parameter int ACC_W   = 16,
    parameter int CNT_W   = 10
) (
    input  logic                          CLK,
    input  logic                          RST,
    dsp_overpack_unpack_acc_if.slave      bus
);
    localparam int F_W = FIELD_W + 1;

    typedef enum logic [0:0] {
        ST_FIRST = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    e_valid_q, e_valid_d;
    logic                    e_last_q, e_last_d;
    logic signed [F_W-1:0]   f_q [NFIELD];
    logic signed [F_W-1:0]   f_d [NFIELD];
    logic signed [ACC_W-1:0] acc_q [NFIELD];
    logic signed [ACC_W-1:0] acc_d [NFIELD];
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NFIELD*ACC_W-1:0] acc_out_q, acc_out_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    out_valid_q, out_valid_d;

    logic                    in_ready_s;
    logic                    accept_s;
    logic signed [ACC_W-1:0] sum_s [NFIELD];
    logic [CNT_W-1:0]        cnt_next_s;

    // Saturating add of a 7-bit field into an accumulator; overflow shows as the
    // two top bits of the widened sum disagreeing.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [F_W-1:0]   b
    );
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W+1-F_W){b[F_W-1]}}, b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat_add = s[ACC_W-1:0];
        end
    endfunction

    assign in_ready_s   = !RST && !(out_valid_q && !bus.out_ready) && !(e_valid_q && e_last_q);
    assign accept_s     = bus.p_valid && in_ready_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.acc_out   = acc_out_q;
    assign bus.beat_cnt  = beat_cnt_q;
    assign bus.out_valid = out_valid_q;

    // Extract stage: each field above slot 0 gets back the borrow its lower
    // neighbour's sign bit took out of it.
    always_comb begin
        e_valid_d = accept_s;
        e_last_d  = accept_s && bus.p_last;
        f_d[0]    = {bus.P[FIELD_W-1], bus.P[FIELD_W-1:0]};
        for (int k = 1; k < NFIELD; k++) begin
            f_d[k] = {bus.P[k*FIELD_W+FIELD_W-1], bus.P[k*FIELD_W +: FIELD_W]}
                   + {{FIELD_W{1'b0}}, bus.P[k*FIELD_W-1]};
        end
    end

    // Accumulate stage and result/handshake register update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_out_d   = acc_out_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        for (int k = 0; k < NFIELD; k++) begin
            acc_d[k] = acc_q[k];
            sum_s[k] = sat_add((state_q == ST_FIRST) ? {ACC_W{1'b0}} : acc_q[k], f_q[k]);
        end
        if (state_q == ST_FIRST) begin
            cnt_next_s = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_next_s = cnt_q;
        end else begin
            cnt_next_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (e_valid_q) begin
            for (int k = 0; k < NFIELD; k++) begin
                acc_d[k] = sum_s[k];
            end
            cnt_d   = cnt_next_s;
            state_d = e_last_q ? ST_FIRST : ST_RUN;
        end else begin
            state_d = state_q;
        end

        // A new result may load on the same edge as a handshake; intake gating
        // guarantees the old one has been taken by then.
        if (e_valid_q && e_last_q) begin
            for (int k = 0; k < NFIELD; k++) begin
                acc_out_d[k*ACC_W +: ACC_W] = sum_s[k];
            end
            beat_cnt_d  = cnt_next_s;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // All state, synchronously cleared.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_FIRST;
            e_valid_q   <= 1'b0;
            e_last_q    <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            acc_out_q   <= {(NFIELD*ACC_W){1'b0}};
            beat_cnt_q  <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            for (int k = 0; k < NFIELD; k++) begin
                f_q[k]   <= {F_W{1'b0}};
                acc_q[k] <= {ACC_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            e_valid_q   <= e_valid_d;
            e_last_q    <= e_last_d;
            cnt_q       <= cnt_d;
            acc_out_q   <= acc_out_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            for (int k = 0; k < NFIELD; k++) begin
                f_q[k]   <= f_d[k];
                acc_q[k] <= acc_d[k];
            end
        end
    end
endmodule

// File: tb/tb_dsp_overpack_unpack_acc.sv
// Scoreboard bench: P words are built by true signed packing of six products,
// and expected run sums are queued as beats are accepted.
module tb_dsp_overpack_unpack_acc;
    typedef int prod_t [6];
    typedef struct packed {
        logic [95:0] acc;
        logic [9:0]  cnt;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t  exp_q [$];
    int    model_acc [6];
    int    model_cnt   = 0;
    bit    model_first = 1'b1;

    dsp_overpack_unpack_acc_if #(.NFIELD(6), .ACC_W(16), .CNT_W(10)) ifm ();
    dsp_overpack_unpack_acc_if #(.NFIELD(6), .ACC_W(8),  .CNT_W(10)) if8 ();

    dsp_overpack_unpack_acc #(.FIELD_W(6), .NFIELD(6), .ACC_W(16), .CNT_W(10)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (ifm.slave)
    );

    dsp_overpack_unpack_acc #(.FIELD_W(6), .NFIELD(6), .ACC_W(8), .CNT_W(10)) dut8 (
        .CLK (CLK),
        .RST (RST),
        .bus (if8.slave)
    );

    always #5 CLK = ~CLK;

    function automatic logic [47:0] pack(input prod_t p);
        longint s;
        s = 0;
        for (int k = 0; k < 6; k++) begin
            s = s + (longint'(p[k]) <<< (6 * k));
        end
        return s[47:0];
    endfunction

    function automatic void mk(input int w0, input int w1, input int a0, input int a1,
                               input int a2, output prod_t p);
        p[0] = w0 * a0; p[1] = w0 * a1; p[2] = w0 * a2;
        p[3] = w1 * a0; p[4] = w1 * a1; p[5] = w1 * a2;
    endfunction

    // Scoreboard: each handshake seen before the edge is compared against the queue head.
    always @(negedge CLK) begin
        if (!RST && ifm.out_valid && ifm.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got acc=%h cnt=%0d, required none", ifm.acc_out, ifm.beat_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({ifm.acc_out, ifm.beat_cnt} !== {e.acc, e.cnt}) begin
                    errors++;
                    $display("FAIL result: got acc=%h cnt=%0d, required acc=%h cnt=%0d",
                             ifm.acc_out, ifm.beat_cnt, e.acc, e.cnt);
                end
            end
        end
    end

    task automatic model_beat(input prod_t p, input bit last);
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            int s;
            logic [31:0] t;
            s = (model_first ? 0 : model_acc[k]) + p[k];
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            model_acc[k] = s;
            t = s;
            e.acc[k*16 +: 16] = t[15:0];
        end
        model_cnt = model_first ? 1 : ((model_cnt == 1023) ? 1023 : model_cnt + 1);
        if (last) begin
            e.cnt = model_cnt[9:0];
            exp_q.push_back(e);
        end
        model_first = last;
    endtask

    // Presents one beat and holds it until accepted; returns at posedge+1.
    task automatic send_beat(input prod_t p, input bit last, output int waits);
        bit done;
        done = 1'b0;
        waits = 0;
        ifm.P = pack(p);
        ifm.p_valid = 1'b1;
        ifm.p_last = last;
        while (!done) begin
            @(negedge CLK);
            if (ifm.in_ready) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", waits);
                    done = 1'b1;
                end
            end
        end
        @(posedge CLK);
        #1;
        if (waits <= 100) model_beat(p, last);
        ifm.p_valid = 1'b0;
        ifm.p_last = 1'b0;
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        ifm.p_valid = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_first = 1'b1;
        model_cnt = 0;
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle(2);
        @(negedge CLK);
        checks++;
        if ({ifm.in_ready, ifm.out_valid, ifm.acc_out, ifm.beat_cnt} !== 108'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b acc=%h cnt=%0d, required all 0",
                     ifm.in_ready, ifm.out_valid, ifm.acc_out, ifm.beat_cnt);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (ifm.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", ifm.in_ready);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_single();
        prod_t p;
        int w;
        mk(1, 1, 1, 2, 3, p);
        send_beat(p, 1'b1, w);
        @(negedge CLK);
        checks++;
        if (ifm.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%b one edge after accept, required 0", ifm.out_valid);
        end
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checks++;
        if (ifm.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: got out_valid=%b two edges after accept, required 1", ifm.out_valid);
        end
        idle(3);
    endtask

    task automatic test_borrow();
        prod_t p;
        int w;
        mk(-1, 0, 1, 0, 0, p);
        send_beat(p, 1'b1, w);
        idle(4);
        mk(-3, 2, 5, 1, 4, p);
        send_beat(p, 1'b1, w);
        idle(4);
    endtask

    task automatic test_back_to_back();
        prod_t p;
        int w;
        int total;
        total = 0;
        mk(1, 1, 1, 2, 3, p);
        for (int i = 0; i < 4; i++) begin
            send_beat(p, i == 3, w);
            total += w;
        end
        checks++;
        if (total !== 0) begin
            errors++;
            $display("FAIL b2b_stalls: got %0d stall cycles, required 0", total);
        end
        @(negedge CLK);
        checks++;
        if (ifm.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL last_block: got in_ready=%b after last beat, required 0", ifm.in_ready);
        end
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checks++;
        if (ifm.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL last_block_len: got in_ready=%b second cycle, required 1", ifm.in_ready);
        end
        idle(4);
    endtask

    task automatic test_saturate();
        bit    stalled;
        bit    seen;
        stalled = 1'b0;
        seen = 1'b0;
        if8.P = 48'd7;
        for (int i = 0; i < 20; i++) begin
            if8.p_valid = 1'b1;
            if8.p_last = (i == 19);
            @(negedge CLK);
            if (!if8.in_ready) stalled = 1'b1;
            @(posedge CLK);
            #1;
        end
        if8.p_valid = 1'b0;
        if8.p_last = 1'b0;
        checks++;
        if (stalled) begin
            errors++;
            $display("FAIL sat_intake: got in_ready=0 during run, required 1");
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            seen = if8.out_valid;
        end
        checks++;
        if ({seen, if8.acc_out, if8.beat_cnt} !== {1'b1, 48'h0000_0000_007F, 10'd20}) begin
            errors++;
            $display("FAIL saturate: got vld=%b acc=%h cnt=%0d, required vld=1 acc=00000000007f cnt=20",
                     seen, if8.acc_out, if8.beat_cnt);
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        prod_t p1;
        prod_t p2;
        int w;
        p1 = '{2, -1, 3, -2, 1, 0};
        p2 = '{-5, 4, 0, 7, -3, 1};
        ifm.out_ready = 1'b0;
        send_beat(p1, 1'b0, w);
        send_beat(p1, 1'b1, w);
        fork
            begin
                bit seen;
                bit bad;
                seen = 1'b0;
                bad = 1'b0;
                for (int i = 0; i < 10 && !seen; i++) begin
                    @(negedge CLK);
                    seen = ifm.out_valid;
                end
                for (int i = 0; i < 10; i++) begin
                    @(negedge CLK);
                    if (exp_q.size() == 0 || ifm.in_ready !== 1'b0 || ifm.out_valid !== 1'b1 ||
                        ifm.acc_out !== exp_q[0].acc) bad = 1'b1;
                end
                checks++;
                if (!seen || bad) begin
                    errors++;
                    $display("FAIL stall_hold: got seen=%b unstable=%b rdy=%b acc=%h, required seen=1 unstable=0",
                             seen, bad, ifm.in_ready, ifm.acc_out);
                end
                @(posedge CLK);
                #1;
                ifm.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    send_beat(p2, i == 2, w);
                end
            end
        join
        idle(5);
    endtask

    task automatic test_reset_mid();
        prod_t p;
        int w;
        bit seen;
        p = '{5, 5, 5, 5, 5, 5};
        send_beat(p, 1'b0, w);
        send_beat(p, 1'b0, w);
        do_reset(1);
        mk(1, 1, 1, 2, 3, p);
        send_beat(p, 1'b1, w);
        idle(4);
        ifm.out_ready = 1'b0;
        send_beat(p, 1'b1, w);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            seen = ifm.out_valid;
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checks++;
        if ({seen, ifm.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_drop: got seen=%b out_valid=%b, required seen=1 out_valid=0", seen, ifm.out_valid);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
        model_first = 1'b1;
        ifm.out_ready = 1'b1;
        idle(4);
    endtask

    initial begin
        ifm.P = 48'd0;
        ifm.p_valid = 1'b0;
        ifm.p_last = 1'b0;
        ifm.out_ready = 1'b1;
        if8.P = 48'd0;
        if8.p_valid = 1'b0;
        if8.p_last = 1'b0;
        if8.out_ready = 1'b1;
        test_reset();
        test_single();
        test_borrow();
        test_back_to_back();
        test_saturate();
        test_backpressure();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
